// File: rtl/btb_access_controller_if.sv
// Request/grant and array-port bundle between fetch/execute, the BTB access
// controller and the single-port BTB storage array.
interface btb_access_controller_if #(
  parameter int XLEN        = 64,
  parameter int NUM_ENTRIES = 128
);
  localparam int IDXW = $clog2(NUM_ENTRIES);

  logic                lookup_valid_i;
  logic [XLEN-1:0]     lookup_pc_i;
  logic                lookup_ready_o;
  logic                upd_valid_i;
  logic [XLEN-1:0]     upd_curr_addr_i;
  logic [XLEN-1:0]     upd_next_addr_i;
  logic                upd_is_jump_i;
  logic                upd_ready_o;
  logic                flush_i;
  logic                flush_busy_o;
  logic                mem_en_o;
  logic                mem_we_o;
  logic [IDXW-1:0]     mem_idx_o;
  logic                mem_valid_o;
  logic [XLEN-3:0]     mem_c_addr_o;
  logic [XLEN-3:0]     mem_n_addr_o;

  modport slave (
    input  lookup_valid_i, lookup_pc_i,
    input  upd_valid_i, upd_curr_addr_i, upd_next_addr_i, upd_is_jump_i,
    input  flush_i,
    output lookup_ready_o, upd_ready_o, flush_busy_o,
    output mem_en_o, mem_we_o, mem_idx_o, mem_valid_o, mem_c_addr_o, mem_n_addr_o
  );

  modport master (
    output lookup_valid_i, lookup_pc_i,
    output upd_valid_i, upd_curr_addr_i, upd_next_addr_i, upd_is_jump_i,
    output flush_i,
    input  lookup_ready_o, upd_ready_o, flush_busy_o,
    input  mem_en_o, mem_we_o, mem_idx_o, mem_valid_o, mem_c_addr_o, mem_n_addr_o
  );
endinterface

// File: rtl/btb_access_controller.sv
// Arbitrates the single BTB array port between fetch lookups, buffered
// execute updates and a one-entry-per-cycle invalidate-all flush sequence.
module btb_access_controller #(
  parameter int XLEN        = 64,
  parameter int NUM_ENTRIES = 128,
  parameter int UPD_DEPTH   = 4
) (
  input logic                   clk_i,
  input logic                   arst_ni,
  btb_access_controller_if.slave bus
);
  localparam int IDXW = $clog2(NUM_ENTRIES);
  localparam int PTRW = $clog2(UPD_DEPTH);
  localparam int AW   = XLEN - 2;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e            r_state, w_state_nxt;
  logic [IDXW-1:0]   r_flush_cnt, w_flush_cnt_nxt;

  logic [AW-1:0]        r_fifo_curr [UPD_DEPTH];
  logic [AW-1:0]        r_fifo_next [UPD_DEPTH];
  logic [UPD_DEPTH-1:0] r_fifo_jump;
  logic [PTRW-1:0]      r_head, r_tail;
  logic [PTRW:0]        r_count;

  logic            w_full, w_empty, w_push, w_pop;
  logic            w_lookup_ready;
  logic            w_mem_en, w_mem_we, w_mem_valid;
  logic [IDXW-1:0] w_mem_idx;
  logic [AW-1:0]   w_mem_c_addr, w_mem_n_addr;
  logic            w_unused;

  assign w_full  = (r_count == (PTRW+1)'(UPD_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.upd_valid_i && !w_full;

  assign w_unused = ^{bus.lookup_pc_i[XLEN-1:IDXW+2], bus.lookup_pc_i[1:0],
                      bus.upd_curr_addr_i[1:0], bus.upd_next_addr_i[1:0]};

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // A full FIFO outranks fetch so execute can never be starved indefinitely.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_pop           = 1'b0;
    w_lookup_ready  = 1'b0;
    w_mem_en        = 1'b0;
    w_mem_we        = 1'b0;
    w_mem_idx       = '0;
    w_mem_valid     = 1'b0;
    w_mem_c_addr    = '0;
    w_mem_n_addr    = '0;
    case (r_state)
      IDLE: begin
        if (bus.flush_i) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = '0;
        end
        if (w_full || (!bus.lookup_valid_i && !w_empty)) begin
          w_pop        = 1'b1;
          w_mem_en     = 1'b1;
          w_mem_we     = 1'b1;
          w_mem_idx    = r_fifo_curr[r_head][IDXW-1:0];
          w_mem_valid  = r_fifo_jump[r_head];
          w_mem_c_addr = r_fifo_curr[r_head];
          w_mem_n_addr = r_fifo_next[r_head];
        end else if (bus.lookup_valid_i) begin
          w_lookup_ready = 1'b1;
          w_mem_en       = 1'b1;
          w_mem_idx      = bus.lookup_pc_i[IDXW+1:2];
        end
      end
      FLUSH: begin
        w_mem_en  = 1'b1;
        w_mem_we  = 1'b1;
        w_mem_idx = r_flush_cnt;
        if (bus.flush_i) begin
          w_flush_cnt_nxt = '0;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt + IDXW'(1);
          if (r_flush_cnt == IDXW'(NUM_ENTRIES - 1)) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTRW'(1);
      if (w_pop)  r_head <= r_head + PTRW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTRW+1)'(1);
        2'b01:   r_count <= r_count - (PTRW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_curr[r_tail] <= bus.upd_curr_addr_i[XLEN-1:2];
      r_fifo_next[r_tail] <= bus.upd_next_addr_i[XLEN-1:2];
      r_fifo_jump[r_tail] <= bus.upd_is_jump_i;
    end
  end

  assign bus.lookup_ready_o = w_lookup_ready;
  assign bus.upd_ready_o    = !w_full;
  assign bus.flush_busy_o   = (r_state == FLUSH);
  assign bus.mem_en_o       = w_mem_en;
  assign bus.mem_we_o       = w_mem_we;
  assign bus.mem_idx_o      = w_mem_idx;
  assign bus.mem_valid_o    = w_mem_valid;
  assign bus.mem_c_addr_o   = w_mem_c_addr;
  assign bus.mem_n_addr_o   = w_mem_n_addr;
endmodule
